// File: rtl/hpt_image_drawer.sv
// Frame redraw engine: on a change of the one-hot image select, streams every pixel of
// the selected sprite from a synchronous ROM to a 160x120 VGA adapter as x/y/colour/plot.
module hpt_image_drawer #(
    parameter int unsigned WIDTH   = 160,
    parameter int unsigned HEIGHT  = 120,
    parameter int unsigned NUM_IMG = 10,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IMG-1:0] image,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [COLOR_W-1:0] colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] IDX_NONE = 4'hF;
    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  x_c;
    logic [6:0]  y_c;
    logic [3:0]  cur_idx, pend_idx, dec_idx;
    logic        pending, img_valid;
    logic        start, issue, finish, retire, last_px;
    int unsigned hot_cnt;

    always_comb begin
        hot_cnt = 0;
        dec_idx = '0;
        for (int unsigned i = 0; i < NUM_IMG; i++) begin
            if (image[i]) begin
                hot_cnt = hot_cnt + 1;
                dec_idx = 4'(i);
            end
        end
        img_valid = (hot_cnt == 1);
    end

    assign last_px = (x_c == X_LAST) && (y_c == Y_LAST);
    assign colour  = rom_data;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: if (pending) begin
                state_next = DRAW;
                start      = 1'b1;
            end
            DRAW: begin
                issue = 1'b1;
                if (last_px) state_next = FLUSH;
            end
            FLUSH: begin
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                retire     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster order over a full-width frame makes the address a plain increment from the image base.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_c      <= '0;
            y_c      <= '0;
            x        <= '0;
            y        <= '0;
            rom_addr <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_idx  <= IDX_NONE;
            pend_idx <= '0;
            pending  <= 1'b0;
        end else begin
            plot <= issue;
            done <= finish;
            if (issue) begin
                x <= x_c;
                y <= y_c;
                if (!last_px) begin
                    rom_addr <= rom_addr + 1'b1;
                    if (x_c == X_LAST) begin
                        x_c <= '0;
                        y_c <= y_c + 1'b1;
                    end else begin
                        x_c <= x_c + 1'b1;
                    end
                end
            end
            if (start) begin
                cur_idx  <= pend_idx;
                x_c      <= '0;
                y_c      <= '0;
                rom_addr <= ADDR_W'(pend_idx) * ADDR_W'(WIDTH * HEIGHT);
                busy     <= 1'b1;
                pending  <= 1'b0;
            end
            if (retire) busy <= 1'b0;
            // A fresh change seen on the consuming cycle re-arms pending for the following frame.
            if (img_valid && (dec_idx != (pending ? pend_idx : cur_idx))) begin
                pend_idx <= dec_idx;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hpt_image_drawer.sv
// Directed bench for hpt_image_drawer on a 4x2 frame with a ROM returning addr[2:0].
module tb_hpt_image_drawer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] image;
    logic [7:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[2:0];
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    hpt_image_drawer #(
        .WIDTH(4), .HEIGHT(2), .NUM_IMG(10), .ADDR_W(8), .COLOR_W(3)
    ) dut (
        .clk(clk), .resetn(resetn), .image(image), .rom_addr(rom_addr),
        .rom_data(rom_data), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for busy, then walks one whole frame; optionally changes image mid-frame.
    task automatic check_frame(input int base, input int switch_k, input logic [9:0] new_img);
        for (int n = 0; n < 10 && busy !== 1'b1; n++) @(negedge clk);
        check("busy_rise", busy, 1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rom_addr[%0d]", k), rom_addr, base + k);
            @(negedge clk);
            check($sformatf("plot[%0d]", k), plot, 1);
            check($sformatf("x[%0d]", k), x, k % 4);
            check($sformatf("y[%0d]", k), y, k / 4);
            check($sformatf("colour[%0d]", k), colour, (base + k) % 8);
            if (k == switch_k) image = new_img;
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("plot_after_last", plot, 0);
        check("busy_during_done", busy, 1);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        resetn = 1'b0;
        image  = '0;
        repeat (3) @(negedge clk);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_addr", rom_addr, 0);
        resetn = 1'b1;

        image = 10'b0000000100;
        check_frame(16, -1, '0);

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("hold_plot", plot, 0);
            check("hold_busy", busy, 0);
        end

        image = 10'b0000000000;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("zero_busy", busy, 0);
        end
        image = 10'b0000010010;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("multi_busy", busy, 0);
        end
        image = 10'b0000000100;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("same_idx_busy", busy, 0);
        end

        done_cnt = 0;
        image = 10'b0000000001;
        check_frame(0, 2, 10'b1000000000);
        check_frame(72, -1, '0);
        repeat (10) @(negedge clk);
        check("done_count", done_cnt, 2);
        check("idle_after_pair", busy, 0);

        image = 10'b0000000100;
        for (int n = 0; n < 10 && busy !== 1'b1; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("mid_plot", plot, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_plot", plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", rom_addr, 0);
        resetn = 1'b1;
        check_frame(16, -1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
